alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Issue controller between instruction decode and the ALU/shifter/multiplier/HiLo datapath.
- Accepts one funct code per valid/ready handshake and drives registered per-unit control codes and result-mux select.
- Sequences the multi-cycle shift-add MUL, then a single HiLo write.
- Back-pressures decode while MUL is in flight, so MFHI/MFLO can never read stale HiLo.

Parameters:
- MUL_CYCLES, 32, number of cycles the multiplier runs; legal range 2..127.
- CNT_W, 7, width of the internal MUL cycle counter; must satisfy 2^CNT_W > MUL_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- op_valid  in  1  decode presents a funct code this cycle.
- funct  in  6  R-type funct code.
- op_ready  out  1  sequencer can accept this cycle; combinational, equals (state==IDLE).
- alu_ctl  out  6  control code to ALU.
- sht_ctl  out  6  control code to shifter.
- mul_ctl  out  6  control code to multiplier/HiLo.
- mul_run  out  1  multiplier iterating.
- hilo_we  out  1  HiLo register write strobe.
- mux_sel  out  2  result mux select: 0 ALU, 1 SHT, 2 HI, 3 LO.
- result_valid  out  1  datapath result valid this cycle.
- illegal  out  1  unsupported funct was accepted.

Behaviour:
- Funct codes:
  - ALU ops: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010.
  - Shifter op: SLL 000000.
  - Multiplier ops: MUL 011001, MFHI 010000, MFLO 010010.
- Accept = op_valid & op_ready. funct is sampled only on accept.
- All outputs except op_ready are registered.
- Reset values: alu_ctl=0, sht_ctl=0, mul_ctl=0, mux_sel=0, mul_run=0, hilo_we=0, result_valid=0, illegal=0, counter=0, state=IDLE.
- States: IDLE, MUL_RUN, MUL_WB.
- IDLE, accept of an ALU op: next cycle alu_ctl=funct, mux_sel=0, result_valid=1 for exactly 1 cycle. Remains IDLE, so back-to-back accepts are allowed.
- IDLE, accept of SLL: next cycle sht_ctl=000000, mux_sel=1, result_valid=1 for 1 cycle.
- IDLE, accept of MFHI or MFLO: next cycle mux_sel=2 or 3 respectively, result_valid=1 for 1 cycle.
- IDLE, accept of MUL:
  - Next state MUL_RUN, counter cleared to 0.
  - mul_run=1 and mul_ctl=011001 for exactly MUL_CYCLES cycles.
  - Counter increments each MUL_RUN cycle.
  - At counter==MUL_CYCLES-1 the next state is MUL_WB.
- MUL_WB: lasts 1 cycle.
  - hilo_we=1, mul_ctl=111111 (HiLo open code), mul_run=0, result_valid=0.
  - Next state IDLE.
- MUL latency: op_ready is low for MUL_CYCLES+1 cycles after the accept edge. An MFHI issued immediately after MUL is accepted on the first IDLE cycle following MUL_WB.
- Unsupported funct accepted: illegal=1 for 1 cycle, result_valid=0, no unit control changes, state stays IDLE.
- Idle cycles with no accept:
  - result_valid, illegal and hilo_we return to 0.
  - alu_ctl, sht_ctl and mux_sel hold their last values.
  - mul_ctl returns to 0 outside MUL_RUN/MUL_WB.
- Reset at any point, including mid-MUL: all outputs and the counter return to reset values on the next edge. hilo_we must not pulse for the aborted MUL.
- op_valid or funct changing while op_ready=0: ignored, no effect on counter or outputs.

Optional Feature:
- Macro: STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt [15:0], reset to 0.
  - Increments by 1 every cycle where op_valid=1 and op_ready=0.
  - Saturates at 16'hFFFF, no wrap.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- reset high 2 cycles, then release -> all outputs 0, op_ready=1.
- accept ADD, then SLT back-to-back -> cycle+1 alu_ctl=100000, result_valid=1; cycle+2 alu_ctl=101010, mux_sel=0, result_valid=1.
- accept MUL, hold MFHI on op_valid -> mul_run high exactly 32 cycles; hilo_we pulses in cycle 33; MFHI accepted in cycle 34; result_valid with mux_sel=2 in cycle 35.
- reset asserted at MUL counter=10 -> next cycle mul_run=0, state IDLE; hilo_we never pulses.
- accept funct 111000 -> illegal=1 for 1 cycle, result_valid=0, op_ready stays 1.
- STALL_CNT_EN defined, op_valid held through a full MUL -> stall_cnt=33 after MUL_WB.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Issue controller: accepts one R-type funct per handshake and drives registered unit controls.
// Optional macro STALL_CNT_EN adds a saturating stall_cnt output counting back-pressured requests.
module alu_op_sequencer #(
    parameter int MUL_CYCLES = 32,
    parameter int CNT_W      = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_valid,
    input  logic [5:0] funct,
    output logic       op_ready,
    output logic [5:0] alu_ctl,
    output logic [5:0] sht_ctl,
    output logic [5:0] mul_ctl,
    output logic       mul_run,
    output logic       hilo_we,
    output logic [1:0] mux_sel,
    output logic       result_valid,
`ifdef STALL_CNT_EN
    output logic [15:0] stall_cnt,
`endif
    output logic       illegal
);

    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_MUL  = 6'b011001;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] HILO_OPEN = 6'b111111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        MUL_WB  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        C_ALU  = 3'd0,
        C_SHT  = 3'd1,
        C_MUL  = 3'd2,
        C_MFHI = 3'd3,
        C_MFLO = 3'd4,
        C_ILL  = 3'd5
    } op_class_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [5:0]       alu_ctl_reg;
    logic [5:0]       sht_ctl_reg;
    logic [5:0]       mul_ctl_reg;
    logic             mul_run_reg;
    logic             hilo_we_reg;
    logic [1:0]       mux_sel_reg;
    logic             result_valid_reg;
    logic             illegal_reg;

    op_class_t        op_class_next;
    logic             accept;

    assign op_ready     = (state_reg == IDLE);
    assign accept       = op_valid & op_ready;
    assign alu_ctl      = alu_ctl_reg;
    assign sht_ctl      = sht_ctl_reg;
    assign mul_ctl      = mul_ctl_reg;
    assign mul_run      = mul_run_reg;
    assign hilo_we      = hilo_we_reg;
    assign mux_sel      = mux_sel_reg;
    assign result_valid = result_valid_reg;
    assign illegal      = illegal_reg;

    always_comb begin
        op_class_next = C_ILL;
        case (funct)
            F_AND, F_OR, F_ADD, F_SUB, F_SLT: op_class_next = C_ALU;
            F_SLL:                            op_class_next = C_SHT;
            F_MUL:                            op_class_next = C_MUL;
            F_MFHI:                           op_class_next = C_MFHI;
            F_MFLO:                           op_class_next = C_MFLO;
            default:                          op_class_next = C_ILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            alu_ctl_reg      <= '0;
            sht_ctl_reg      <= '0;
            mul_ctl_reg      <= '0;
            mul_run_reg      <= 1'b0;
            hilo_we_reg      <= 1'b0;
            mux_sel_reg      <= 2'd0;
            result_valid_reg <= 1'b0;
            illegal_reg      <= 1'b0;
        end else begin
            // Strobes default low; steering controls hold unless an op overwrites them.
            result_valid_reg <= 1'b0;
            illegal_reg      <= 1'b0;
            hilo_we_reg      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    mul_ctl_reg <= '0;
                    mul_run_reg <= 1'b0;
                    if (accept) begin
                        case (op_class_next)
                            C_ALU: begin
                                alu_ctl_reg      <= funct;
                                mux_sel_reg      <= 2'd0;
                                result_valid_reg <= 1'b1;
                            end
                            C_SHT: begin
                                sht_ctl_reg      <= F_SLL;
                                mux_sel_reg      <= 2'd1;
                                result_valid_reg <= 1'b1;
                            end
                            C_MFHI: begin
                                mux_sel_reg      <= 2'd2;
                                result_valid_reg <= 1'b1;
                            end
                            C_MFLO: begin
                                mux_sel_reg      <= 2'd3;
                                result_valid_reg <= 1'b1;
                            end
                            C_MUL: begin
                                state_reg   <= MUL_RUN;
                                cnt_reg     <= '0;
                                mul_run_reg <= 1'b1;
                                mul_ctl_reg <= F_MUL;
                            end
                            default: illegal_reg <= 1'b1;
                        endcase
                    end
                end
                MUL_RUN: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(MUL_CYCLES - 1)) begin
                        state_reg   <= MUL_WB;
                        mul_run_reg <= 1'b0;
                        hilo_we_reg <= 1'b1;
                        mul_ctl_reg <= HILO_OPEN;
                    end
                end
                MUL_WB: begin
                    state_reg   <= IDLE;
                    mul_ctl_reg <= '0;
                end
                default: begin
                    state_reg   <= IDLE;
                    mul_ctl_reg <= '0;
                    mul_run_reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    assign stall_cnt = stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else if (op_valid && !op_ready && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized and directed bench for alu_op_sequencer, checked against a busy-countdown model.
module tb_alu_op_sequencer;

    localparam int MC = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       op_valid = 1'b0;
    logic [5:0] funct = 6'd0;
    logic       op_ready;
    logic [5:0] alu_ctl, sht_ctl, mul_ctl;
    logic       mul_run, hilo_we, result_valid, illegal;
    logic [1:0] mux_sel;
`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int total = 0;
    int bad = 0;

    // Model: m_busy counts cycles left until the sequencer is ready again.
    int         m_busy = 0;
    int         e_stall = 0;
    logic [5:0] e_alu = 0, e_sht = 0;
    logic [1:0] e_mux = 0;
    logic       e_rv = 0, e_ill = 0;

    logic [5:0] codes [0:8] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010,
                                6'b101010, 6'b000000, 6'b011001, 6'b010000, 6'b010010};

    always #5 clk = ~clk;

    alu_op_sequencer #(.MUL_CYCLES(MC), .CNT_W(7)) dut (
        .clk(clk),
        .reset(reset),
        .op_valid(op_valid),
        .funct(funct),
        .op_ready(op_ready),
        .alu_ctl(alu_ctl),
        .sht_ctl(sht_ctl),
        .mul_ctl(mul_ctl),
        .mul_run(mul_run),
        .hilo_we(hilo_we),
        .mux_sel(mux_sel),
        .result_valid(result_valid),
`ifdef STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .illegal(illegal)
    );

    function automatic logic e_mul_run();
        return m_busy >= 2;
    endfunction

    function automatic logic e_hilo();
        return m_busy == 1;
    endfunction

    function automatic logic [5:0] e_mulctl();
        if (m_busy >= 2) return 6'b011001;
        if (m_busy == 1) return 6'b111111;
        return 6'b000000;
    endfunction

    // Drive one cycle of inputs, step past the edge and advance the model.
    task automatic cycle(input logic r, input logic v, input logic [5:0] f);
        logic rdy;
        reset = r;
        op_valid = v;
        funct = f;
        @(posedge clk);
        #1;
        if (r) begin
            m_busy = 0; e_stall = 0; e_alu = 0; e_sht = 0; e_mux = 0; e_rv = 0; e_ill = 0;
        end else begin
            rdy = (m_busy == 0);
            if (v && !rdy && e_stall != 16'hFFFF) e_stall++;
            e_rv = 0;
            e_ill = 0;
            if (m_busy > 0) m_busy--;
            if (v && rdy) begin
                case (f)
                    6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010: begin
                        e_alu = f; e_mux = 0; e_rv = 1;
                    end
                    6'b000000: begin e_sht = 0; e_mux = 1; e_rv = 1; end
                    6'b010000: begin e_mux = 2; e_rv = 1; end
                    6'b010010: begin e_mux = 3; e_rv = 1; end
                    6'b011001: m_busy = MC + 1;
                    default:   e_ill = 1;
                endcase
            end
        end
    endtask

    task automatic test_reset();
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        total++;
        if ({alu_ctl, sht_ctl, mul_ctl, mul_run, hilo_we, mux_sel, result_valid, illegal} !== 25'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {alu_ctl, sht_ctl, mul_ctl, mul_run, hilo_we, mux_sel, result_valid, illegal});
        end
        total++;
        if (op_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", op_ready); end
`ifdef STALL_CNT_EN
        total++;
        if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall got=%0d want=0", stall_cnt); end
`endif
    endtask

    task automatic test_back_to_back();
        cycle(0, 1, 6'b100000);
        total++;
        if (alu_ctl !== 6'b100000 || result_valid !== 1'b1 || mux_sel !== 2'd0) begin
            bad++;
            $display("FAIL b2b_add got alu=%b rv=%b mux=%0d want alu=100000 rv=1 mux=0", alu_ctl, result_valid, mux_sel);
        end
        cycle(0, 1, 6'b101010);
        total++;
        if (alu_ctl !== 6'b101010 || result_valid !== 1'b1 || mux_sel !== 2'd0) begin
            bad++;
            $display("FAIL b2b_slt got alu=%b rv=%b mux=%0d want alu=101010 rv=1 mux=0", alu_ctl, result_valid, mux_sel);
        end
        cycle(0, 0, 6'b000000);
        total++;
        if (alu_ctl !== 6'b101010 || result_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_hold got alu=%b rv=%b want alu=101010 rv=0", alu_ctl, result_valid);
        end
        cycle(0, 1, 6'b000000);
        total++;
        if (mux_sel !== 2'd1 || result_valid !== 1'b1 || sht_ctl !== 6'd0 || alu_ctl !== 6'b101010) begin
            bad++;
            $display("FAIL b2b_sll got mux=%0d rv=%b sht=%b alu=%b want mux=1 rv=1 sht=0 alu=101010", mux_sel, result_valid, sht_ctl, alu_ctl);
        end
        $display("back_to_back: ADD, SLT, SLL issued");
    endtask

    task automatic test_mul_mfhi();
        int run_cnt = 0, nready = 0, hilo_at = -1, rv_at = -1, mux_at_rv = -1;
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 1, 6'b011001);
        for (int i = 1; i <= 40; i++) begin
            if (mul_run === 1'b1) run_cnt++;
            if (op_ready === 1'b0) nready++;
            if (hilo_we === 1'b1 && hilo_at < 0) hilo_at = i;
            if (result_valid === 1'b1 && rv_at < 0) begin rv_at = i; mux_at_rv = mux_sel; end
`ifdef STALL_CNT_EN
            if (i == 34) begin
                total++;
                if (stall_cnt !== 16'd33) begin bad++; $display("FAIL mul_stall_cnt got=%0d want=33", stall_cnt); end
            end
`endif
            cycle(0, i <= 34, 6'b010000);
        end
        total++;
        if (run_cnt != MC) begin bad++; $display("FAIL mul_run_len got=%0d want=%0d", run_cnt, MC); end
        total++;
        if (nready != MC + 1) begin bad++; $display("FAIL mul_busy_len got=%0d want=%0d", nready, MC + 1); end
        total++;
        if (hilo_at != MC + 1) begin bad++; $display("FAIL mul_hilo_cycle got=%0d want=%0d", hilo_at, MC + 1); end
        total++;
        if (rv_at != MC + 3 || mux_at_rv != 2) begin
            bad++;
            $display("FAIL mul_mfhi got cycle=%0d mux=%0d want cycle=%0d mux=2", rv_at, mux_at_rv, MC + 3);
        end
        $display("mul_mfhi: run=%0d hilo@%0d mfhi_result@%0d", run_cnt, hilo_at, rv_at);
    endtask

    task automatic test_reset_mid_mul();
        int hilo_seen = 0;
        cycle(0, 1, 6'b011001);
        for (int i = 1; i <= 10; i++) cycle(0, 0, 0);
        cycle(1, 0, 0);
        total++;
        if (mul_run !== 1'b0 || op_ready !== 1'b1 || mul_ctl !== 6'd0) begin
            bad++;
            $display("FAIL abort_state got run=%b rdy=%b mulctl=%b want 0 1 0", mul_run, op_ready, mul_ctl);
        end
        for (int i = 0; i < MC + 8; i++) begin
            cycle(0, 0, 0);
            if (hilo_we !== 1'b0) hilo_seen++;
        end
        total++;
        if (hilo_seen != 0) begin bad++; $display("FAIL abort_hilo got pulses=%0d want 0", hilo_seen); end
        $display("reset_mid_mul: aborted at counter 10");
    endtask

    task automatic test_illegal();
        logic [5:0] alu_before;
        logic [1:0] mux_before;
        cycle(0, 1, 6'b100101);
        alu_before = 6'b100101;
        mux_before = 2'd0;
        cycle(0, 1, 6'b111000);
        total++;
        if (illegal !== 1'b1 || result_valid !== 1'b0 || op_ready !== 1'b1) begin
            bad++;
            $display("FAIL illegal_flag got ill=%b rv=%b rdy=%b want 1 0 1", illegal, result_valid, op_ready);
        end
        total++;
        if (alu_ctl !== alu_before || mux_sel !== mux_before) begin
            bad++;
            $display("FAIL illegal_nochange got alu=%b mux=%0d want alu=%b mux=%0d", alu_ctl, mux_sel, alu_before, mux_before);
        end
        cycle(0, 0, 0);
        total++;
        if (illegal !== 1'b0) begin bad++; $display("FAIL illegal_pulse got=%b want=0", illegal); end
        $display("illegal: funct 111000 flagged");
    endtask

    task automatic test_random();
        int errs_before = bad;
        for (int n = 0; n < 1500; n++) begin
            logic r, v;
            logic [5:0] f;
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) f = 6'($urandom);
            else f = codes[$urandom_range(0, 8)];
            cycle(r, v, f);
            total++;
            if (op_ready !== (m_busy == 0) || alu_ctl !== e_alu || sht_ctl !== e_sht || mux_sel !== e_mux
                || result_valid !== e_rv || illegal !== e_ill || mul_run !== e_mul_run()
                || hilo_we !== e_hilo() || mul_ctl !== e_mulctl()) begin
                bad++;
                $display("FAIL random_%0d got rdy=%b alu=%b sht=%b mux=%0d rv=%b ill=%b run=%b we=%b mctl=%b want rdy=%b alu=%b sht=%b mux=%0d rv=%b ill=%b run=%b we=%b mctl=%b",
                         n, op_ready, alu_ctl, sht_ctl, mux_sel, result_valid, illegal, mul_run, hilo_we, mul_ctl,
                         m_busy == 0, e_alu, e_sht, e_mux, e_rv, e_ill, e_mul_run(), e_hilo(), e_mulctl());
            end
`ifdef STALL_CNT_EN
            total++;
            if (stall_cnt !== 16'(e_stall)) begin
                bad++;
                $display("FAIL random_stall_%0d got=%0d want=%0d", n, stall_cnt, e_stall);
            end
`endif
        end
        $display("random: 1500 cycles, new errors=%0d", bad - errs_before);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mul_mfhi();
        test_reset_mid_mul();
        test_illegal();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
